// File: rtl/gait_pkg.sv
// gait_pkg: shared constants, FSM state type and the 4-step crab-leg gait table
package gait_pkg;
    localparam int POS_W = 8;
    localparam int NSTEPS = 4;
    localparam logic [POS_W-1:0] HOME_LIFT = 8'd128;
    localparam logic [POS_W-1:0] HOME_SWING = 8'd128;
    typedef enum logic [1:0] {IDLE, RUN, PARK} state_t;
    localparam logic [POS_W-1:0] LIFT_TBL [NSTEPS] = '{HOME_LIFT, 8'd200, 8'd200, HOME_LIFT};
    localparam logic [POS_W-1:0] SWING_TBL [NSTEPS] = '{HOME_SWING, HOME_SWING, 8'd64, 8'd64};
    function automatic logic [1:0] step_next(input logic [1:0] s, input logic dir);
        return dir ? s - 2'd1 : s + 2'd1;
    endfunction
endpackage

// File: rtl/tick_edge_sync.sv
// tick_edge_sync: synchronises the asynchronous tick and emits a one-cycle pulse per rising edge
module tick_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick_in,
    output logic tick_rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic hist;
    // synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tick_in};
            hist <= sync[SYNC_STAGES-1];
        end
    end
    assign tick_rise = sync[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/gait_sequencer.sv
// gait_sequencer: steps a crab leg through a 4-step gait, one step per tick rising edge
module gait_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int POS_W = gait_pkg::POS_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick_in,
    input  logic             enable,
    input  logic             reverse,
    output logic [POS_W-1:0] lift_pos,
    output logic [POS_W-1:0] swing_pos,
    output logic [1:0]       step_idx,
    output logic             step_strobe,
    output logic             busy
);
    import gait_pkg::*;
    state_t state, state_nx;
    logic tick_rise, do_step, step_dir, park_dir, park_dir_nx;
    logic [1:0] step_nx;
    tick_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rstn(rstn),
        .tick_in(tick_in),
        .tick_rise(tick_rise)
    );
    // state, step counter and registered servo targets
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            step_idx <= 2'd0;
            park_dir <= 1'b0;
            lift_pos <= HOME_LIFT;
            swing_pos <= HOME_SWING;
            step_strobe <= 1'b0;
        end else begin
            state <= state_nx;
            step_idx <= step_nx;
            park_dir <= park_dir_nx;
            lift_pos <= LIFT_TBL[step_nx];
            swing_pos <= SWING_TBL[step_nx];
            step_strobe <= do_step;
        end
    end
    // transitions and step decisions, evaluated only on tick edges
    always_comb begin
        state_nx = state;
        do_step = 1'b0;
        step_dir = reverse;
        park_dir_nx = park_dir;
        if (tick_rise) begin
            case (state)
                IDLE: begin
                    state_nx = enable ? RUN : IDLE;
                    do_step = enable;
                end
                RUN: begin
                    if (enable) begin
                        do_step = 1'b1;
                    end else if (step_idx != 2'd0) begin
                        state_nx = PARK;
                        do_step = 1'b1;
                        park_dir_nx = reverse;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                PARK: begin
                    do_step = 1'b1;
                    if (enable) begin
                        state_nx = RUN;
                    end else begin
                        step_dir = park_dir;
                        state_nx = (step_next(step_idx, park_dir) == 2'd0) ? IDLE : PARK;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        step_nx = do_step ? step_next(step_idx, step_dir) : step_idx;
    end
    // status output decoded from the state register only
    always_comb begin
        busy = (state != IDLE);
    end
endmodule

// File: doc/gait_sequencer.md
Name: gait_sequencer

Overview:
Consumes the slow square-wave tick from the pump-bits divider and steps the crab leg through a fixed 4-step gait, one step per rising tick edge. Outputs registered 8-bit lift and swing position targets for the downstream servo PWM stage. Supports forward and reverse stepping. Dropping enable parks the leg at the home step before going idle.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on tick_in (legal values ≥2).
POS_W, 8, width of each servo position output; must equal gait_pkg::POS_W.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous, active-low reset
tick_in  in  1  slow square wave from the pump-bits divider; treated as asynchronous
enable  in  1  1 = walk; 0 = park at home, then idle
reverse  in  1  0 = step index +1, 1 = step index −1 (mod 4)
lift_pos  out  POS_W  lift servo target
swing_pos  out  POS_W  swing servo target
step_idx  out  2  current gait step
step_strobe  out  1  one-cycle pulse in the cycle after step_idx changes
busy  out  1  high when state ≠ IDLE

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, step_idx=0, lift_pos=swing_pos=128, step_strobe=0, busy=0, all sync/edge flops=0.
- Input capture: tick_in passes through SYNC_STAGES flops plus one history flop. tick_rise = last sync stage & ~history.
- Latency (SYNC_STAGES=2): tick_in first sampled high at edge E0, then tick_rise is high between E1 and E2. At E2, step_idx, lift_pos, swing_pos and step_strobe update. step_strobe clears at E3.
- Gait table (gait_pkg), step → (lift, swing): 0 → (128,128) home; 1 → (200,128); 2 → (200,64); 3 → (128,64).
- lift_pos and swing_pos are registered. They are always equal to the table entry for the registered step_idx. No combinational path from any input to any output.
- Step arithmetic: 2-bit, wrap-around. Forward 3 → 0; reverse 0 → 3.
- FSM states: IDLE, RUN, PARK. Transitions are evaluated only on cycles with tick_rise; otherwise the state holds.
  - IDLE, enable=1: go to RUN. Step once in the direction given by reverse (0 → 1 forward, 0 → 3 reverse).
  - IDLE, enable=0: stay in IDLE. No step, no strobe.
  - RUN, enable=1: step once using the current value of reverse.
  - RUN, enable=0, step_idx≠0: latch park_dir=reverse, go to PARK, step once in park_dir.
  - RUN, enable=0, step_idx=0: go to IDLE. No step.
  - PARK, enable=0: step once in park_dir. If the new step_idx is 0, go to IDLE on that same edge. Changes to reverse are ignored in PARK.
  - PARK, enable=1: go to RUN and step once using the current value of reverse.
- step_strobe pulses only when step_idx actually changes.
- enable and reverse are sampled only on tick_rise cycles; between ticks they are don't-care.
- A tick_in glitch shorter than one clk period may be missed; the bench does not rely on this case.
- tick_in held high does not retrigger a step; each step needs a low→high transition.
- Reset asserted mid-step (including in the same cycle as tick_rise): reset wins and all reset values apply immediately. After reset releases, the first step needs a new rising edge on tick_in.

Decomposition:
- gait_pkg holds: POS_W=8, NSTEPS=4, HOME_LIFT=128, HOME_SWING=128, the state enum {IDLE,RUN,PARK}, and the 4-entry gait table as constant arrays.
- One sub-module, tick_edge_sync (parameter SYNC_STAGES). It is async-reset to 0 and outputs a single-cycle tick_rise.
- The FSM, step counter and output registers stay in gait_sequencer.

Test Plan:
- Reset, then 3 cycles of idle clock → step_idx=0, lift_pos=128, swing_pos=128, busy=0, step_strobe=0.
- enable=1, reverse=0, 5 tick_in rising edges → step_idx sequence 1,2,3,0,1. Positions (200,128),(200,64),(128,64),(128,128),(200,128). Exactly one strobe per edge, each at E2 relative to that edge's first sample.
- enable=1, reverse=1, starting from IDLE, 2 ticks → step_idx 3, then 2. Positions (128,64), then (200,64).
- Walking forward at step 2, set enable=0 and toggle reverse during parking → next ticks give step_idx 3, then 0. busy drops on the edge that reaches 0. A further tick produces no strobe.
- At step 1 in PARK, re-assert enable with reverse=1 → next tick gives RUN, step_idx=0 with a strobe. The following tick gives step_idx=3.
- Hold tick_in high for 100 cycles → one step only. Pulse rstn low at the same cycle as tick_rise → outputs go to (0, 128, 128) asynchronously, with no stale step after rstn is released.
